// File: rtl/sonar_echo_timer.sv
// rtl/sonar_echo_timer.sv - sonar trigger generator and echo width timer with tick prescaler
// Optional macro SONAR_ECHO_SYNC_EN adds a two-flop synchroniser on the echo pin.
module sonar_echo_timer #(
  parameter int WIDTH         = 32,
  parameter int CLKS_PER_TICK = 50,
  parameter int TRIG_TICKS    = 10,
  parameter int TIMEOUT_TICKS = 38000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             echo,
  output logic             trig,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [WIDTH-1:0] width
);

  localparam int PW   = $clog2(CLKS_PER_TICK);
  localparam int MAXT = (TRIG_TICKS > TIMEOUT_TICKS) ? TRIG_TICKS : TIMEOUT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLKS_PER_TICK - 1);
  localparam logic [CW-1:0]    TRIG_LAST  = CW'(TRIG_TICKS - 1);
  localparam logic [CW-1:0]    TO_LAST    = CW'(TIMEOUT_TICKS - 1);
  localparam logic [WIDTH-1:0] WIDTH_LAST = WIDTH'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [WIDTH-1:0] width_q, width_d;
  logic             timeout_q, timeout_d;
  logic             echo_p_q;
  logic             echo_s;
  logic             rise, fall, tick;
  logic [PW-1:0]    presc_adv;

`ifdef SONAR_ECHO_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], echo};
    end
  end

  assign echo_s = sync_q[1];
`else
  assign echo_s = echo;
`endif

  assign rise      = echo_s & ~echo_p_q;
  assign fall      = ~echo_s & echo_p_q;
  assign tick      = (presc_q == PRESC_LAST);
  assign presc_adv = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      width_q    <= '0;
      timeout_q  <= 1'b0;
      echo_p_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      width_q    <= width_d;
      timeout_q  <= timeout_d;
      echo_p_q   <= echo_s;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    width_d    = width_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_TRIG;
          presc_d    = '0;
          tick_cnt_d = '0;
          width_d    = '0;
          timeout_d  = 1'b0;
        end
      end
      S_TRIG: begin
        presc_d = presc_adv;
        if (tick) begin
          if (tick_cnt_q == TRIG_LAST) begin
            state_d    = S_WAIT_RISE;
            presc_d    = '0;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_RISE: begin
        presc_d = presc_adv;
        // A rise beats a timeout tick landing on the same cycle.
        if (rise) begin
          state_d = S_MEASURE;
          presc_d = PW'(1);
          width_d = '0;
        end else if (tick) begin
          if (tick_cnt_q == TO_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            width_d   = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_MEASURE: begin
        if (echo_s) begin
          presc_d = presc_adv;
          if (tick) begin
            width_d = width_q + 1'b1;
          end
        end
        if (echo_s && tick && (width_q == WIDTH_LAST)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (fall) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      presc_d    = '0;
      tick_cnt_d = '0;
      width_d    = '0;
      timeout_d  = 1'b0;
    end
  end

  always_comb begin
    trig    = (state_q == S_TRIG);
    busy    = (state_q == S_TRIG) || (state_q == S_WAIT_RISE) || (state_q == S_MEASURE);
    done    = (state_q == S_DONE);
    timeout = timeout_q;
    width   = width_q;
  end

endmodule

// File: tb/tb_sonar_echo_timer.sv
// tb/tb_sonar_echo_timer.sv - directed bench with cycle-level behavioural model for sonar_echo_timer
module tb_sonar_echo_timer;

  localparam int WIDTH = 8;
  localparam int CPT   = 5;
  localparam int TRIGT = 2;
  localparam int TOT   = 20;
`ifdef SONAR_ECHO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             echo;
  logic             trig;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [WIDTH-1:0] width;

  int errors = 0;
  int checks = 0;
  int n;

  sonar_echo_timer #(
    .WIDTH(WIDTH),
    .CLKS_PER_TICK(CPT),
    .TRIG_TICKS(TRIGT),
    .TIMEOUT_TICKS(TOT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .echo(echo),
    .trig(trig),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .width(width)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 trigger, 2 wait for echo, 3 measuring, 4 done.
  int m_ph = 0, m_cnt = 0, m_high = 0, m_width = 0;
  bit m_to = 0, m_prev = 0, m_e1 = 0, m_e2 = 0, m_es = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = 0; m_cnt = 0; m_high = 0; m_width = 0;
      m_to = 0; m_prev = 0; m_e1 = 0; m_e2 = 0;
    end else begin
      m_es = (LAT == 2) ? m_e2 : echo;
      if (abort && m_ph != 0) begin
        m_ph = 0; m_width = 0; m_to = 0;
      end else begin
        case (m_ph)
          0: if (start && !abort) begin
               m_ph = 1; m_cnt = 0; m_width = 0; m_to = 0;
             end
          1: begin
               m_cnt++;
               if (m_cnt == TRIGT * CPT) begin m_ph = 2; m_cnt = 0; end
             end
          2: if (m_es && !m_prev) begin
               m_ph = 3; m_high = 1; m_width = 0;
             end else begin
               m_cnt++;
               if (m_cnt == TOT * CPT) begin m_ph = 4; m_to = 1; m_width = 0; end
             end
          3: if (m_es) begin
               m_high++;
               m_width = m_high / CPT;
               if (m_width == TOT) begin m_ph = 4; m_to = 1; end
             end else begin
               m_ph = 4;
             end
          default: m_ph = 0;
        endcase
      end
      m_prev = m_es;
      m_e2 = m_e1;
      m_e1 = echo;
    end
  end

  always @(negedge clk) begin
    chk("cycle", {20'd0, trig, busy, done, timeout, width},
        {20'd0, (m_ph == 1), (m_ph >= 1 && m_ph <= 3), (m_ph == 4), m_to, WIDTH'(m_width)});
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_trig(output int c);
    c = 0;
    while (trig === 1'b1 && c < 50) begin
      c++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (done !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    start = 0; abort = 0; echo = 0; reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_width", width, 0);
    reset = 1;
    @(negedge clk);

    // Normal measurement of 37 high cycles
    pulse_start();
    chk("trig_start", trig, 1);
    chk("busy_start", busy, 1);
    count_trig(n);
    chk("trig_len", n, 10);
    chk("wait_busy", busy, 1);
    echo = 1;
    repeat (37) @(negedge clk);
    echo = 0;
    wait_done(n);
    chk("done_lat", n, 1 + LAT);
    chk("meas_width", width, 7);
    chk("meas_timeout", timeout, 0);
    @(negedge clk);
    chk("after_done_busy", busy, 0);
    chk("after_done_done", done, 0);

    // start with abort in IDLE stays idle
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("idle_abort_start", busy, 0);

    // No echo at all
    pulse_start();
    count_trig(n);
    wait_done(n);
    chk("noecho_lat", n, 100);
    chk("noecho_timeout", timeout, 1);
    chk("noecho_width", width, 0);
    @(negedge clk);
    pulse_start();
    chk("start_clears_to", timeout, 0);

    // Echo already high on entry, then a real rise that stays high
    echo = 1;
    count_trig(n);
    repeat (3) @(negedge clk);
    echo = 0;
    @(negedge clk);
    echo = 1;
    wait_done(n);
    chk("stuck_lat", n, 100 + LAT);
    chk("stuck_width", width, 20);
    chk("stuck_timeout", timeout, 1);
    echo = 0;
    @(negedge clk);

    // start during MEASURE ignored, then abort
    pulse_start();
    count_trig(n);
    echo = 1;
    repeat (5) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    chk("meas_partial", width, 2);
    chk("meas_busy", busy, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_trig", trig, 0);
    chk("abort_done", done, 0);
    chk("abort_width", width, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);
    echo = 0;

    // Asynchronous reset in the middle of TRIG
    pulse_start();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("async_rst", {27'd0, trig, busy, done, timeout, 1'b0} | {24'd0, width}, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    pulse_start();
    count_trig(n);
    chk("post_rst_trig_len", n, 10);
    echo = 1;
    repeat (12) @(negedge clk);
    echo = 0;
    wait_done(n);
    chk("post_rst_lat", n, 1 + LAT);
    chk("post_rst_width", width, 2);
    chk("post_rst_timeout", timeout, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
